sm83_adr_seq: RTL

- Parametrised successor of the SM83 address latch/incrementer.
- Holds the address latch (AL) and provides a ±1 incrementer/decrementer of configurable width, plus a forced-high-byte mode.
- Adds an autonomous burst sequencer that walks AL through N consecutive addresses without per-cycle control, for the OAM-DMA-style block-copy path.
- Sits between the decoder's address controls and the external address pins.

---
 rtl/sm83_adr_pkg.sv | 47 ++++
 rtl/sm83_adr_incdec.sv | 66 ++++++
 rtl/sm83_adr_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sm83_adr_pkg.sv
// ---------------------------------------------------------------------------
// sm83_adr_pkg
// Shared definitions for the SM83 address latch / burst sequencer.
//   burst_state_e : burst sequencer state (IDLE, RUN)
//   INCDEC_MAX_W  : widest address the incdec() reference function handles
//   INCDEC_GRP_W  : carry-lookahead group width used by sm83_adr_incdec
//   incdec()      : behavioural +/-1 with carry-in, returns {wrap, result};
//                   the lookahead sub-module must agree with it bit for bit
// ---------------------------------------------------------------------------
package sm83_adr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } burst_state_e;

    localparam int unsigned INCDEC_MAX_W = 32;
    localparam int unsigned INCDEC_GRP_W = 4;

    // Width-generic reference: only the low 'width' bits of value are used.
    function automatic logic [INCDEC_MAX_W:0] incdec(
        input logic [INCDEC_MAX_W-1:0] value,
        input int unsigned             width,
        input logic                    dec,
        input logic                    cy
    );
        logic [INCDEC_MAX_W-1:0] mask;
        logic [INCDEC_MAX_W-1:0] v;
        logic [INCDEC_MAX_W-1:0] r;
        logic                    wrap;
        mask = (width >= INCDEC_MAX_W) ? '1
             : ((INCDEC_MAX_W'(1) << width) - INCDEC_MAX_W'(1));
        v = value & mask;
        if (!cy) begin
            r    = v;
            wrap = 1'b0;
        end else if (dec) begin
            r    = (v - INCDEC_MAX_W'(1)) & mask;
            wrap = (v == '0);
        end else begin
            r    = (v + INCDEC_MAX_W'(1)) & mask;
            wrap = (v == mask);
        end
        return {wrap, r};
    endfunction

endpackage

// File: rtl/sm83_adr_incdec.sv
// ---------------------------------------------------------------------------
// sm83_adr_incdec
// Combinational +/-1 incrementer with grouped carry lookahead.
//   val_i  [W] : value to adjust
//   dec_i      : 1 = decrement, 0 = increment
//   cy_i       : carry-in / enable; 0 passes val_i through unchanged
//   res_o  [W] : adjusted value, modulo 2^W
//   wrap_o     : carry (inc) or borrow (dec) out of the MSB
// A decrement is an increment on complemented bits: bit i flips when every
// lower bit is 1 (inc) or 0 (dec). Bits are XORed with dec_i so both cases
// reduce to "all lower adjusted bits are 1". Each group of INCDEC_GRP_W bits
// produces one enable (AND of its adjusted bits); group carries chain across
// those enables and ripple only inside a group.
// ---------------------------------------------------------------------------
module sm83_adr_incdec
    import sm83_adr_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    input  logic         cy_i,
    output logic [W-1:0] res_o,
    output logic         wrap_o
);

    localparam int GRP = int'(INCDEC_GRP_W);
    localparam int NG  = (int'(W) + GRP - 1) / GRP;
    localparam int PW  = NG * GRP;

    logic [PW-1:0] t_pad;   // complement-adjusted bits, padded with ones
    logic [PW-1:0] c_pad;   // carry into each bit position
    logic [NG-1:0] grp_en;  // group passes a carry straight through
    logic [NG:0]   grp_cy;  // carry into each group

    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first,
        // so no path through the block can leave it unassigned (latch).
        t_pad        = '1;
        t_pad[W-1:0] = val_i ^ {W{dec_i}};
        grp_en       = '0;
        grp_cy       = '0;
        c_pad        = '0;

        for (int g = 0; g < NG; g++) begin
            grp_en[g] = &t_pad[g*GRP +: GRP];
        end

        grp_cy[0] = cy_i;
        for (int g = 0; g < NG; g++) begin
            grp_cy[g+1] = grp_cy[g] & grp_en[g];
        end

        for (int g = 0; g < NG; g++) begin
            c_pad[g*GRP] = grp_cy[g];
            for (int b = 1; b < GRP; b++) begin
                c_pad[g*GRP+b] = c_pad[g*GRP+b-1] & t_pad[g*GRP+b-1];
            end
        end

        res_o  = val_i ^ c_pad[W-1:0];
        // Padding bits are ones, so the last group carry is the true MSB carry.
        wrap_o = grp_cy[NG];
    end

endmodule

// File: rtl/sm83_adr_seq.sv
// ---------------------------------------------------------------------------
// sm83_adr_seq
// SM83 address latch (AL) with +/-1 incrementer, forced-high-byte load and
// an autonomous burst sequencer for block-copy transfers.
// AL, the burst FSM and its counter all update on the falling clock edge.
// Ports:
//   clk, reset            : core clock, synchronous active-high reset
//   ain         [ADR_W]   : address bus input
//   aout        [ADR_W]   : current AL value
//   apin        [ADR_W]   : value AL takes at the next falling edge (pins)
//   ctl_al_we             : load AL (IDLE only)
//   ctl_al_hi_ff          : force upper HI_W bits to ones on a plain load
//   ctl_inc_dec           : 1 = decrement, 0 = increment
//   ctl_inc_cy            : incrementer enable / carry-in
//   ctl_inc_oe            : load the incrementer result instead of ain
//   burst_start           : start a burst at ain (IDLE, burst_len != 0)
//   burst_len   [CNT_W]   : number of addresses in the burst
//   burst_hold            : pause a running burst (optional feature)
//   burst_busy            : burst in progress
//   burst_done            : one-cycle pulse after the last burst address
//   inc_wrap              : carry/borrow out of the incrementer MSB
// Build option: define SM83_ADR_BURST_HOLD_EN to make burst_hold freeze a
// running burst; otherwise burst_hold is ignored.
// ---------------------------------------------------------------------------
module sm83_adr_seq
    import sm83_adr_pkg::*;
#(
    parameter int unsigned ADR_W = 16,
    parameter int unsigned HI_W  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADR_W-1:0] ain,
    output logic [ADR_W-1:0] aout,
    output logic [ADR_W-1:0] apin,
    input  logic             ctl_al_we,
    input  logic             ctl_al_hi_ff,
    input  logic             ctl_inc_dec,
    input  logic             ctl_inc_cy,
    input  logic             ctl_inc_oe,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_hold,
    output logic             burst_busy,
    output logic             burst_done,
    output logic             inc_wrap
);

    burst_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
    logic [ADR_W-1:0] al_q;
    logic [ADR_W-1:0] al_d;

    logic             hold_eff;
    logic             start_ok;
    logic             run_step;
    logic             inc_dec;
    logic             inc_cy;
    logic [ADR_W-1:0] inc_res;
    logic [ADR_W-1:0] load_val;

`ifdef SM83_ADR_BURST_HOLD_EN
    assign hold_eff = burst_hold;
`else
    logic unused_burst_hold;
    assign unused_burst_hold = burst_hold;
    assign hold_eff          = 1'b0;
`endif

    assign start_ok = (state_q == IDLE) && burst_start && (burst_len != '0);
    // A running burst advances only while more than one address remains.
    assign run_step = (state_q == RUN) && (cnt_q > CNT_W'(1)) && !hold_eff;

    // While bursting, the incrementer follows the latched direction and is
    // enabled exactly on stepping cycles, so inc_wrap reports burst wraps.
    always_comb begin
        inc_dec = ctl_inc_dec;
        inc_cy  = ctl_inc_cy;
        if (state_q == RUN) begin
            inc_dec = dir_q;
            inc_cy  = run_step;
        end
    end

    sm83_adr_incdec #(
        .W (ADR_W)
    ) u_incdec (
        .val_i  (al_q),
        .dec_i  (inc_dec),
        .cy_i   (inc_cy),
        .res_o  (inc_res),
        .wrap_o (inc_wrap)
    );

    // Plain load: incrementer result wins over the forced high field.
    always_comb begin
        load_val = ctl_inc_oe ? inc_res : ain;
        if (!ctl_inc_oe && ctl_al_hi_ff) begin
            load_val[ADR_W-1 -: HI_W] = '1;
        end
    end

    // Next AL is computed combinationally because it also drives the pins.
    always_comb begin
        al_d = al_q;
        if (reset) begin
            al_d = '0;
        end else if (state_q == IDLE) begin
            if (start_ok) begin
                al_d = ain;
            end else if (ctl_al_we) begin
                al_d = load_val;
            end
        end else if (run_step) begin
            al_d = inc_res;
        end
    end

    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            al_q <= '0;
        end else begin
            al_q <= al_d;
        end
    end

    // Burst FSM with registered busy/done outputs.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= RUN;
                        cnt_q   <= burst_len;
                        dir_q   <= ctl_inc_dec;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!hold_eff) begin
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            // Last address stays on AL for the done cycle.
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign aout       = al_q;
    assign apin       = al_d;
    assign burst_busy = busy_q;
    assign burst_done = done_q;

endmodule
